// File: rtl/uart_pkg.sv
// Shared definitions for the UART packet controller: parser states,
// error codes and the default sync byte.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        DROP    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_LEN = 2'd0;
    localparam logic [1:0] ERR_OVF = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte-stream input, FIFO read side and packet status of the packet controller.
interface uart_rx_pkt_ctrl_if #(
    parameter int DBIT    = 8,
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 16
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(MAX_LEN) + 1;

    logic            s_tick;
    logic            rx_done_tick;
    logic [DBIT-1:0] rx_dout;
    logic            rd_en;
    logic [DBIT-1:0] rd_data;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            pkt_valid;
    logic [LW-1:0]   pkt_len;
    logic            pkt_err;
    logic [1:0]      err_code;
    logic            busy;

    modport slave (
        input  s_tick, rx_done_tick, rx_dout, rd_en,
        output rd_data, fifo_empty, fifo_count, pkt_valid, pkt_len,
               pkt_err, err_code, busy
    );

    modport master (
        output s_tick, rx_done_tick, rx_dout, rd_en,
        input  rd_data, fifo_empty, fifo_count, pkt_valid, pkt_len,
               pkt_err, err_code, busy
    );
endinterface

// File: rtl/uart_pkt_fifo.sv
// Payload FIFO with a tentative write pointer: bytes become visible to the
// reader only when committed, and a rollback discards everything since the
// last commit.
module uart_pkt_fifo #(
    parameter int DBIT  = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_wr_en,
    input  logic [DBIT-1:0]          i_wr_data,
    input  logic                     i_commit,
    input  logic                     i_rollback,
    input  logic                     i_rd_en,
    output logic [DBIT-1:0]          o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DBIT-1:0] r_mem [DEPTH];
    logic [AW:0]     r_rd_ptr;
    logic [AW:0]     r_wr_commit;
    logic [AW:0]     r_wr_tent;
    logic [AW:0]     w_count;

    assign w_count   = r_wr_commit - r_rd_ptr;
    assign o_count   = w_count;
    assign o_empty   = (w_count == '0);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Storage write at the tentative pointer; never reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_tent[AW-1:0]] <= i_wr_data;
        end
    end

    // Pointer maintenance: tentative advance, commit, rollback and pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr    <= '0;
            r_wr_commit <= '0;
            r_wr_tent   <= '0;
        end else begin
            if (i_rollback) begin
                r_wr_tent <= r_wr_commit;
            end else if (i_wr_en) begin
                r_wr_tent <= r_wr_tent + 1'b1;
            end
            if (i_commit) begin
                r_wr_commit <= r_wr_tent;
            end
            if (i_rd_en && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet parser behind uart_rx: sync hunt, length, payload, XOR checksum,
// inter-byte timeout; payload staged in uart_pkt_fifo until verified.
//
// state   | meaning
// IDLE    | hunting for the sync byte, other bytes ignored
// LEN     | next byte is the payload length
// PAYLOAD | storing payload bytes tentatively
// CHK     | next byte is the checksum; commit or roll back
// DROP    | swallowing an oversized packet (length + checksum bytes)
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int              DBIT          = 8,
    parameter int              DEPTH         = 16,
    parameter int              MAX_LEN       = 16,
    parameter logic [DBIT-1:0] SYNC          = SYNC_DEFAULT,
    parameter int              TIMEOUT_TICKS = 320
) (
    input  logic               clk,
    input  logic               reset_n,
    uart_rx_pkt_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_TICKS);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_TICKS - 1);
    localparam logic [DBIT:0] REM_ONE  = (DBIT+1)'(1);

    state_t          r_state;
    logic [DBIT-1:0] r_chk;
    logic [LW-1:0]   r_len;
    logic [DBIT:0]   r_remaining;
    logic [TW-1:0]   r_tmo;
    logic            r_pkt_valid;
    logic            r_pkt_err;
    logic [1:0]      r_err_code;
    logic [LW-1:0]   r_pkt_len;
    logic            r_busy;

    logic            w_wr_en;
    logic            w_commit;
    logic            w_rollback;
    logic            w_timeout;
    logic            w_len_bad;
    logic            w_len_ovf;
    logic [CW-1:0]   w_fifo_count;
    logic [CW-1:0]   w_free;

    // The timer is a down-counter reloaded on every byte; a byte arriving
    // with the terminal tick wins.
    assign w_timeout = (r_state != IDLE) && bus.s_tick && !bus.rx_done_tick
                       && (r_tmo == '0);
    assign w_free    = CW'(DEPTH) - w_fifo_count;
    assign w_len_bad = (bus.rx_dout == '0) || (int'(bus.rx_dout) > MAX_LEN);
    assign w_len_ovf = int'(bus.rx_dout) > int'(w_free);

    // FIFO strobes act on the same edge as the parser's state change.
    always_comb begin
        w_wr_en    = 1'b0;
        w_commit   = 1'b0;
        w_rollback = 1'b0;
        if (w_timeout) begin
            w_rollback = 1'b1;
        end else if (bus.rx_done_tick) begin
            case (r_state)
                PAYLOAD: w_wr_en = 1'b1;
                CHK: begin
                    if (bus.rx_dout == r_chk) w_commit   = 1'b1;
                    else                      w_rollback = 1'b1;
                end
                default: ;
            endcase
        end
    end

    uart_pkt_fifo #(.DBIT(DBIT), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (bus.rx_dout),
        .i_commit   (w_commit),
        .i_rollback (w_rollback),
        .i_rd_en    (bus.rd_en),
        .o_rd_data  (bus.rd_data),
        .o_count    (w_fifo_count),
        .o_empty    (bus.fifo_empty)
    );

    assign bus.fifo_count = w_fifo_count;
    assign bus.pkt_valid  = r_pkt_valid;
    assign bus.pkt_err    = r_pkt_err;
    assign bus.err_code   = r_err_code;
    assign bus.pkt_len    = r_pkt_len;
    assign bus.busy       = r_busy;

    // Parser FSM with timer, checksum and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_chk       <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_tmo       <= '0;
            r_pkt_valid <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_err_code  <= ERR_LEN;
            r_pkt_len   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_pkt_valid <= 1'b0;
            r_pkt_err   <= 1'b0;
            if (w_timeout) begin
                r_pkt_err  <= 1'b1;
                r_err_code <= ERR_TMO;
                r_state    <= IDLE;
                r_busy     <= 1'b0;
            end else if (bus.rx_done_tick) begin
                r_tmo <= TMO_LOAD;
                case (r_state)
                    IDLE: begin
                        if (bus.rx_dout == SYNC) begin
                            r_state <= LEN;
                            r_busy  <= 1'b1;
                            r_chk   <= '0;
                        end
                    end
                    LEN: begin
                        r_chk <= bus.rx_dout;
                        r_len <= bus.rx_dout[LW-1:0];
                        if (w_len_bad) begin
                            r_pkt_err  <= 1'b1;
                            r_err_code <= ERR_LEN;
                            r_state    <= IDLE;
                            r_busy     <= 1'b0;
                        end else if (w_len_ovf) begin
                            r_pkt_err   <= 1'b1;
                            r_err_code  <= ERR_OVF;
                            r_remaining <= {1'b0, bus.rx_dout} + REM_ONE;
                            r_state     <= DROP;
                        end else begin
                            r_remaining <= {1'b0, bus.rx_dout};
                            r_state     <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        r_chk       <= r_chk ^ bus.rx_dout;
                        r_remaining <= r_remaining - REM_ONE;
                        if (r_remaining == REM_ONE) r_state <= CHK;
                    end
                    CHK: begin
                        if (bus.rx_dout == r_chk) begin
                            r_pkt_valid <= 1'b1;
                            r_pkt_len   <= r_len;
                        end else begin
                            r_pkt_err  <= 1'b1;
                            r_err_code <= ERR_CHK;
                        end
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    DROP: begin
                        r_remaining <= r_remaining - REM_ONE;
                        if (r_remaining == REM_ONE) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end else if ((r_state != IDLE) && bus.s_tick) begin
                r_tmo <= r_tmo - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: framing, error paths, overflow drop,
// timeout, read/commit overlap and mid-packet reset.
module tb_uart_rx_pkt_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n_valid = 0;
    int   n_err = 0;

    uart_rx_pkt_ctrl_if #(.DBIT(8), .DEPTH(16), .MAX_LEN(16)) bus ();

    uart_rx_pkt_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts pulses and flags simultaneous valid/err.
    always @(posedge clk) begin
        #1;
        if (bus.pkt_valid) n_valid++;
        if (bus.pkt_err) n_err++;
        if (bus.pkt_valid || bus.pkt_err) begin
            checks++;
            if (bus.pkt_valid && bus.pkt_err) begin
                failures++;
                $display("FAIL pulse_exclusive: valid=%0b err=%0b required not both", bus.pkt_valid, bus.pkt_err);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit rd = 1'b0);
        @(negedge clk);
        bus.rx_dout      = b;
        bus.rx_done_tick = 1'b1;
        bus.rd_en        = rd;
        @(negedge clk);
        bus.rx_done_tick = 1'b0;
        bus.rd_en        = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.s_tick = 1'b1;
        end
        @(negedge clk);
        bus.s_tick = 1'b0;
    endtask

    // Sends SYNC, len, payload base..base+len-1 and checksum (bad if corrupt).
    task automatic send_pkt(input int len, input logic [7:0] base, input bit corrupt = 1'b0);
        logic [7:0] c;
        c = 8'(len);
        send_byte(8'hA5);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            send_byte(base + 8'(i));
            c = c ^ (base + 8'(i));
        end
        send_byte(corrupt ? ~c : c);
    endtask

    task automatic test_reset();
        bus.s_tick = 0; bus.rx_done_tick = 0; bus.rx_dout = 0; bus.rd_en = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.pkt_valid !== 1'b0) begin failures++; $display("FAIL rst_pkt_valid: got %0b want 0", bus.pkt_valid); end
        checks++; if (bus.pkt_err !== 1'b0) begin failures++; $display("FAIL rst_pkt_err: got %0b want 0", bus.pkt_err); end
        checks++; if (bus.err_code !== 2'd0) begin failures++; $display("FAIL rst_err_code: got %0d want 0", bus.err_code); end
        checks++; if (bus.pkt_len !== 5'd0) begin failures++; $display("FAIL rst_pkt_len: got %0d want 0", bus.pkt_len); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.fifo_empty !== 1'b1) begin failures++; $display("FAIL rst_fifo_empty: got %0b want 1", bus.fifo_empty); end
        checks++; if (bus.fifo_count !== 5'd0) begin failures++; $display("FAIL rst_fifo_count: got %0d want 0", bus.fifo_count); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_good_packet();
        logic [7:0] exp_b [3];
        int v0;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33;
        v0 = n_valid;
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL good_busy: got %0b want 1", bus.busy); end
        send_byte(8'h03);
        checks++; if (bus.pkt_valid !== 1'b1) begin failures++; $display("FAIL good_valid: got %0b want 1", bus.pkt_valid); end
        checks++; if (bus.pkt_len !== 5'd3) begin failures++; $display("FAIL good_len: got %0d want 3", bus.pkt_len); end
        checks++; if (bus.fifo_count !== 5'd3) begin failures++; $display("FAIL good_count: got %0d want 3", bus.fifo_count); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL good_busy_end: got %0b want 0", bus.busy); end
        @(negedge clk);
        checks++; if (n_valid - v0 !== 1) begin failures++; $display("FAIL good_valid_once: got %0d want 1", n_valid - v0); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.rd_data !== exp_b[i]) begin failures++; $display("FAIL good_pop%0d: got %02h want %02h", i, bus.rd_data, exp_b[i]); end
            pop();
        end
        checks++; if (bus.fifo_empty !== 1'b1) begin failures++; $display("FAIL good_empty: got %0b want 1", bus.fifo_empty); end
        pop();
        checks++; if (bus.fifo_count !== 5'd0) begin failures++; $display("FAIL good_pop_empty: got %0d want 0", bus.fifo_count); end
    endtask

    task automatic test_bad_checksum();
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h04);
        checks++; if (bus.pkt_err !== 1'b1) begin failures++; $display("FAIL chk_err: got %0b want 1", bus.pkt_err); end
        checks++; if (bus.err_code !== 2'd2) begin failures++; $display("FAIL chk_code: got %0d want 2", bus.err_code); end
        checks++; if (bus.pkt_valid !== 1'b0) begin failures++; $display("FAIL chk_valid: got %0b want 0", bus.pkt_valid); end
        checks++; if (bus.fifo_count !== 5'd0) begin failures++; $display("FAIL chk_count: got %0d want 0", bus.fifo_count); end
        // A following one-byte packet must land exactly at the old commit point.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        checks++; if (bus.fifo_count !== 5'd1) begin failures++; $display("FAIL chk_rollback_count: got %0d want 1", bus.fifo_count); end
        checks++; if (bus.rd_data !== 8'h7E) begin failures++; $display("FAIL chk_rollback_data: got %02h want 7e", bus.rd_data); end
        pop();
    endtask

    task automatic test_len_errors();
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_byte(8'h00); send_byte(8'hFF);
        @(negedge clk);
        checks++; if (n_valid + n_err - v0 - e0 !== 0) begin failures++; $display("FAIL noise_pulses: got %0d want 0", n_valid + n_err - v0 - e0); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL noise_busy: got %0b want 0", bus.busy); end
        send_byte(8'hA5); send_byte(8'h00);
        checks++; if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd0) begin failures++; $display("FAIL len0: err=%0b code=%0d want err=1 code=0", bus.pkt_err, bus.err_code); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL len0_idle: got %0b want 0", bus.busy); end
        send_byte(8'hA5); send_byte(8'h11);
        checks++; if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd0) begin failures++; $display("FAIL len17: err=%0b code=%0d want err=1 code=0", bus.pkt_err, bus.err_code); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL len17_idle: got %0b want 0", bus.busy); end
    endtask

    task automatic test_overflow();
        int e0, v0;
        logic [7:0] expb;
        send_pkt(10, 8'h01);
        checks++; if (bus.fifo_count !== 5'd10) begin failures++; $display("FAIL ovf_fill: got %0d want 10", bus.fifo_count); end
        e0 = n_err; v0 = n_valid;
        send_byte(8'hA5); send_byte(8'h0A);
        checks++; if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd1) begin failures++; $display("FAIL ovf_code: err=%0b code=%0d want err=1 code=1", bus.pkt_err, bus.err_code); end
        for (int i = 0; i < 10; i++) send_byte(8'hA5);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ovf_drop_busy: got %0b want 1", bus.busy); end
        send_byte(8'h5A);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ovf_drop_done: got %0b want 0", bus.busy); end
        checks++; if (bus.fifo_count !== 5'd10) begin failures++; $display("FAIL ovf_count: got %0d want 10", bus.fifo_count); end
        @(negedge clk);
        checks++; if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin failures++; $display("FAIL ovf_pulses: err=%0d valid=%0d want 1 0", n_err - e0, n_valid - v0); end
        send_pkt(6, 8'h40);
        checks++; if (bus.fifo_count !== 5'd16) begin failures++; $display("FAIL ovf_full: got %0d want 16", bus.fifo_count); end
        checks++; if (bus.pkt_len !== 5'd6) begin failures++; $display("FAIL ovf_len6: got %0d want 6", bus.pkt_len); end
        for (int i = 0; i < 16; i++) begin
            expb = (i < 10) ? 8'(i + 1) : 8'(8'h40 + i - 10);
            checks++; if (bus.rd_data !== expb) begin failures++; $display("FAIL ovf_pop%0d: got %02h want %02h", i, bus.rd_data, expb); end
            pop();
        end
        checks++; if (bus.fifo_empty !== 1'b1) begin failures++; $display("FAIL ovf_empty: got %0b want 1", bus.fifo_empty); end
    endtask

    task automatic test_back_to_back();
        send_pkt(16, 8'h80);
        checks++; if (bus.fifo_count !== 5'd16 || bus.pkt_len !== 5'd16) begin failures++; $display("FAIL maxlen: count=%0d len=%0d want 16 16", bus.fifo_count, bus.pkt_len); end
        for (int i = 0; i < 16; i++) pop();
        send_pkt(2, 8'h20);
        checks++; if (bus.fifo_count !== 5'd2) begin failures++; $display("FAIL b2b_first: got %0d want 2", bus.fifo_count); end
        // Second packet: checksum 03^30^31^32 = 30, with a pop in the commit cycle.
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h30); send_byte(8'h31); send_byte(8'h32);
        send_byte(8'h30, 1'b1);
        checks++; if (bus.pkt_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid: got %0b want 1", bus.pkt_valid); end
        checks++; if (bus.fifo_count !== 5'd4) begin failures++; $display("FAIL b2b_count: got %0d want 4", bus.fifo_count); end
        checks++; if (bus.rd_data !== 8'h21) begin failures++; $display("FAIL b2b_head: got %02h want 21", bus.rd_data); end
        for (int i = 0; i < 4; i++) pop();
    endtask

    task automatic test_timeout();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        ticks(319);
        checks++; if (bus.pkt_err !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL tmo_early: err=%0b busy=%0b want 0 1", bus.pkt_err, bus.busy); end
        ticks(1);
        checks++; if (bus.pkt_err !== 1'b1 || bus.err_code !== 2'd3) begin failures++; $display("FAIL tmo_fire: err=%0b code=%0d want 1 3", bus.pkt_err, bus.err_code); end
        checks++; if (bus.busy !== 1'b0 || bus.fifo_count !== 5'd0) begin failures++; $display("FAIL tmo_state: busy=%0b count=%0d want 0 0", bus.busy, bus.fifo_count); end
        // Byte arrives together with the expiring tick: no timeout.
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        ticks(319);
        @(negedge clk);
        bus.s_tick = 1'b1; bus.rx_done_tick = 1'b1; bus.rx_dout = 8'h22;
        @(negedge clk);
        bus.s_tick = 1'b0; bus.rx_done_tick = 1'b0;
        checks++; if (bus.pkt_err !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL tmo_byte_wins: err=%0b busy=%0b want 0 1", bus.pkt_err, bus.busy); end
        ticks(319);
        send_byte(8'h31);
        checks++; if (bus.pkt_valid !== 1'b1 || bus.fifo_count !== 5'd2) begin failures++; $display("FAIL tmo_recover: valid=%0b count=%0d want 1 2", bus.pkt_valid, bus.fifo_count); end
        checks++; if (bus.rd_data !== 8'h11) begin failures++; $display("FAIL tmo_head: got %02h want 11", bus.rd_data); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rmid_busy_pre: got %0b want 1", bus.busy); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.fifo_count !== 5'd0 || bus.fifo_empty !== 1'b1) begin failures++; $display("FAIL rmid_fifo: count=%0d empty=%0b want 0 1", bus.fifo_count, bus.fifo_empty); end
        checks++; if (bus.pkt_len !== 5'd0 || bus.err_code !== 2'd0) begin failures++; $display("FAIL rmid_status: len=%0d code=%0d want 0 0", bus.pkt_len, bus.err_code); end
        @(negedge clk);
        reset_n = 1'b1;
        send_pkt(4, 8'h50);
        checks++; if (bus.pkt_valid !== 1'b1 || bus.pkt_len !== 5'd4) begin failures++; $display("FAIL rmid_pkt: valid=%0b len=%0d want 1 4", bus.pkt_valid, bus.pkt_len); end
        checks++; if (bus.fifo_count !== 5'd4 || bus.rd_data !== 8'h50) begin failures++; $display("FAIL rmid_data: count=%0d head=%02h want 4 50", bus.fifo_count, bus.rd_data); end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_checksum();
        test_len_errors();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
